// File: rtl/conv_line_engine.sv
// Line-wise convolution engine: reads a job header, a kernel of up to KMAX_LINES
// cache lines and a strided image, then writes one dot-product sum per output word.
module conv_line_engine #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512,
    parameter int DATA_WIDTH  = 32,
    parameter int KMAX_LINES  = 8,
    parameter int LANES       = CACHE_WIDTH / DATA_WIDTH,
    parameter int WB          = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_LMT-1:0]    rd_req_addr,
    output logic [MDATA-1:0]       rd_req_mdata,
    output logic                   rd_req_en,
    input  logic                   rd_req_almostfull,
    input  logic                   rd_rsp_valid,
    input  logic [MDATA-1:0]       rd_rsp_mdata,
    input  logic [CACHE_WIDTH-1:0] rd_rsp_data,
    output logic [ADDR_LMT+WB-1:0] wr_req_addr,
    output logic [MDATA-1:0]       wr_req_mdata,
    output logic [DATA_WIDTH-1:0]  wr_req_data,
    output logic                   wr_req_en,
    output logic                   wr_req_now,
    input  logic                   wr_req_almostfull,
    input  logic                   wr_rsp_valid,
    input  logic                   start,
    output logic                   done,
    output logic                   error
);

    localparam int KIW = (KMAX_LINES > 1) ? $clog2(KMAX_LINES) : 1;

    typedef enum logic [3:0] {
        IDLE, HDR_REQ, HDR_WAIT, HDR_CHECK, KER_REQ, KER_WAIT,
        IMG_REQ, IMG_WAIT, WR_REQ, DRAIN, DONE
    } state_t;

    state_t                  state_q;
    state_t                  waitState_d;
    logic [DATA_WIDTH-1:0]   nOut_q, kLines_q, stride_q;
    logic [ADDR_LMT+WB-1:0]  outBase_q;
    logic [DATA_WIDTH-1:0]   iCnt_q, jCnt_q, acc_q, ackCnt_q;
    logic [DATA_WIDTH-1:0]   iNext_d, jNext_d, dotSum_d;
    logic [MDATA-1:0]        rdTag_q, lastTag_q;
    logic [CACHE_WIDTH-1:0]  kern_q [KMAX_LINES];
    logic [CACHE_WIDTH-1:0]  kernSel_d;
    logic [ADDR_LMT-1:0]     reqAddr_d;
    logic                    rspHit_d, hdrBad_d;

    // Only a response carrying the tag of the single outstanding read is accepted.
    assign rspHit_d  = rd_rsp_valid && (rd_rsp_mdata == lastTag_q);
    assign kernSel_d = kern_q[jCnt_q[KIW-1:0]];
    assign iNext_d   = iCnt_q + 1'b1;
    assign jNext_d   = jCnt_q + 1'b1;
    assign hdrBad_d  = (kLines_q == '0) || (kLines_q > DATA_WIDTH'(KMAX_LINES));

    always_comb begin
        dotSum_d = '0;
        for (int l = 0; l < LANES; l++) begin
            dotSum_d = dotSum_d + rd_rsp_data[l*DATA_WIDTH +: DATA_WIDTH]
                                * kernSel_d[l*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        reqAddr_d   = '0;
        waitState_d = HDR_WAIT;
        case (state_q)
            KER_REQ: begin
                reqAddr_d   = ADDR_LMT'(32'd1 + jCnt_q);
                waitState_d = KER_WAIT;
            end
            IMG_REQ: begin
                reqAddr_d   = ADDR_LMT'(32'd1 + kLines_q + iCnt_q * stride_q + jCnt_q);
                waitState_d = IMG_WAIT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == KER_WAIT && rspHit_d) begin
            kern_q[jCnt_q[KIW-1:0]] <= rd_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            nOut_q       <= '0;
            kLines_q     <= '0;
            stride_q     <= '0;
            outBase_q    <= '0;
            iCnt_q       <= '0;
            jCnt_q       <= '0;
            acc_q        <= '0;
            ackCnt_q     <= '0;
            rdTag_q      <= '0;
            lastTag_q    <= '0;
            rd_req_addr  <= '0;
            rd_req_mdata <= '0;
            rd_req_en    <= 1'b0;
            wr_req_addr  <= '0;
            wr_req_mdata <= '0;
            wr_req_data  <= '0;
            wr_req_en    <= 1'b0;
            wr_req_now   <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            rd_req_en  <= 1'b0;
            wr_req_en  <= 1'b0;
            wr_req_now <= 1'b0;
            if (wr_rsp_valid && state_q != IDLE && state_q != DONE) begin
                ackCnt_q <= ackCnt_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start && !done) begin
                        ackCnt_q <= '0;
                        state_q  <= HDR_REQ;
                    end
                end
                HDR_REQ, KER_REQ, IMG_REQ: begin
                    if (!rd_req_almostfull) begin
                        rd_req_en    <= 1'b1;
                        rd_req_addr  <= reqAddr_d;
                        rd_req_mdata <= rdTag_q;
                        lastTag_q    <= rdTag_q;
                        rdTag_q      <= rdTag_q + 1'b1;
                        state_q      <= waitState_d;
                    end
                end
                HDR_WAIT: begin
                    if (rspHit_d) begin
                        nOut_q    <= rd_rsp_data[0 +: DATA_WIDTH];
                        kLines_q  <= rd_rsp_data[32 +: DATA_WIDTH];
                        stride_q  <= rd_rsp_data[64 +: DATA_WIDTH];
                        outBase_q <= rd_rsp_data[96 +: ADDR_LMT+WB];
                        state_q   <= HDR_CHECK;
                    end
                end
                // A bad kernel size is rejected before any further traffic.
                HDR_CHECK: begin
                    jCnt_q <= '0;
                    if (hdrBad_d) begin
                        done    <= 1'b1;
                        error   <= 1'b1;
                        state_q <= DONE;
                    end else if (nOut_q == '0) begin
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= KER_REQ;
                    end
                end
                KER_WAIT: begin
                    if (rspHit_d) begin
                        if (jNext_d == kLines_q) begin
                            jCnt_q  <= '0;
                            iCnt_q  <= '0;
                            acc_q   <= '0;
                            state_q <= IMG_REQ;
                        end else begin
                            jCnt_q  <= jNext_d;
                            state_q <= KER_REQ;
                        end
                    end
                end
                IMG_WAIT: begin
                    if (rspHit_d) begin
                        acc_q   <= acc_q + dotSum_d;
                        jCnt_q  <= jNext_d;
                        state_q <= (jNext_d == kLines_q) ? WR_REQ : IMG_REQ;
                    end
                end
                WR_REQ: begin
                    if (!wr_req_almostfull) begin
                        wr_req_en    <= 1'b1;
                        wr_req_now   <= 1'b1;
                        wr_req_addr  <= outBase_q + iCnt_q[ADDR_LMT+WB-1:0];
                        wr_req_mdata <= iCnt_q[MDATA-1:0];
                        wr_req_data  <= acc_q;
                        iCnt_q       <= iNext_d;
                        jCnt_q       <= '0;
                        acc_q        <= '0;
                        state_q      <= (iNext_d == nOut_q) ? DRAIN : IMG_REQ;
                    end
                end
                DRAIN: begin
                    if (ackCnt_q == nOut_q) begin
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done    <= 1'b0;
                        error   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
